// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller.
// Holds the default register-address width, the MIPS opcode/funct encodings
// that the control unit decodes into id_is_branch / id_is_md / id_reads_hilo,
// the hazard-cause bundle used inside the controller, and a helper that sizes
// the mult/div busy counter.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;

    // SPECIAL funct codes for the HI/LO datapath
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // One bit per independent stall cause; any set bit stalls the front end.
    typedef struct packed {
        logic load_use;
        logic br_ex;
        logic br_mem;
        logic md;
    } hazard_t;

    // Width needed to hold the values 0..lat inclusive.
    function automatic int md_cnt_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_busy_tracker.sv
// Mult/div occupancy tracker.
// An accepted issue loads the counter with MD_LAT; it then counts down to zero.
// md_busy_o is high while the counter is non-zero, i.e. for exactly MD_LAT
// cycles starting the cycle after the issue. MD_LAT must be at least 1.
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     synchronous reset, active low
//   issue_i    mult/div accepted into EX this cycle
//   md_busy_o  unit occupied
module pipeline_hazard_ctrl_md_busy_tracker
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic issue_i,
    output logic md_busy_o
);

    localparam int CW = md_cnt_width(MD_LAT);

    logic [CW-1:0] md_cnt_q;
    logic [CW-1:0] md_cnt_d;

    // Next count: reload on issue, otherwise count down to zero and hold.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (issue_i) begin
            md_cnt_d = CW'(MD_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end else begin
            md_cnt_d = md_cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy_o = (md_cnt_q != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline, beside the ID stage.
// Detects load-use stalls, branch-in-ID operand stalls (ALU/load result in EX,
// load result in MEM), and HI/LO hazards against a busy mult/div unit.
// Register $0 never creates a dependency. Hazard outputs are combinational so
// the PC and IF/ID registers see them on the same edge. A saturating counter
// records stall cycles for performance monitoring.
// Ports:
//   clk_i, rst_ni                clock, synchronous active-low reset
//   id_rs_i, id_rt_i             source register fields in IF/ID
//   id_uses_rs_i, id_uses_rt_i   instruction really reads rs / rt
//   id_is_branch_i               beq/bne resolving in ID
//   id_is_md_i                   mult/multu/div/divu in ID
//   id_reads_hilo_i              mfhi/mflo in ID
//   ex_mem_read_i, ex_reg_write_i, ex_wr_addr_i   ID/EX load/write/dest
//   mem_mem_read_i, mem_wr_addr_i                 EX/MEM load/dest
//   branch_taken_i               ID branch compare result
//   pc_write_o, ifid_write_o     write enables (low while stalling)
//   ctrl_set_zero_o              inject bubble into ID/EX
//   ifid_flush_o                 squash IF/ID on a resolved taken branch
//   md_busy_o                    mult/div unit occupied
//   stall_cnt_o                  saturating stall-cycle count
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic              id_is_branch_i,
    input  logic              id_is_md_i,
    input  logic              id_reads_hilo_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_reg_write_i,
    input  logic [REG_AW-1:0] ex_wr_addr_i,
    input  logic              mem_mem_read_i,
    input  logic [REG_AW-1:0] mem_wr_addr_i,
    input  logic              branch_taken_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ctrl_set_zero_o,
    output logic              ifid_flush_o,
    output logic              md_busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic             match_ex_s;
    logic             match_mem_s;
    hazard_t          haz_s;
    logic             stall_s;
    logic             md_issue_s;
    logic             md_busy_s;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Operand match against the EX and MEM destinations; $0 is hardwired zero
    // so a write to it can never be a real dependency.
    assign match_ex_s  = (ex_wr_addr_i != '0) &&
                         ((id_uses_rs_i && (ex_wr_addr_i == id_rs_i)) ||
                          (id_uses_rt_i && (ex_wr_addr_i == id_rt_i)));
    assign match_mem_s = (mem_wr_addr_i != '0) &&
                         ((id_uses_rs_i && (mem_wr_addr_i == id_rs_i)) ||
                          (id_uses_rt_i && (mem_wr_addr_i == id_rt_i)));

    // Hazard causes. Branches compare in ID so they cannot use EX forwarding:
    // any write in EX stalls them, and a load in MEM stalls them one more cycle.
    assign haz_s.load_use = ex_mem_read_i && match_ex_s;
    assign haz_s.br_ex    = id_is_branch_i && ex_reg_write_i && match_ex_s;
    assign haz_s.br_mem   = id_is_branch_i && mem_mem_read_i && match_mem_s;
    assign haz_s.md       = md_busy_s && (id_is_md_i || id_reads_hilo_i);

    assign stall_s    = |haz_s;
    // A mult/div held in ID by any stall is not issued.
    assign md_issue_s = id_is_md_i && !stall_s;

    pipeline_hazard_ctrl_md_busy_tracker #(
        .MD_LAT (MD_LAT)
    ) u_md_busy_tracker (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .issue_i   (md_issue_s),
        .md_busy_o (md_busy_s)
    );

    // Front-end control; a stall overrides the taken-branch flush so the
    // branch re-resolves once its operands are ready.
    always_comb begin
        if (stall_s) begin
            pc_write_o      = 1'b0;
            ifid_write_o    = 1'b0;
            ctrl_set_zero_o = 1'b1;
            ifid_flush_o    = 1'b0;
        end else begin
            pc_write_o      = 1'b1;
            ifid_write_o    = 1'b1;
            ctrl_set_zero_o = 1'b0;
            ifid_flush_o    = id_is_branch_i && branch_taken_i;
        end
    end

    // Stall counter next state: one increment per stalled cycle, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign md_busy_o   = md_busy_s;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (REG_AW=5, MD_LAT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic       tk;
        logic       md;
        logic       hilo;
        logic       exr;
        logic       exw;
        logic [4:0] exa;
        logic       memr;
        logic [4:0] mema;
    } in_t;

    typedef struct {
        in_t   in;
        logic  stall;
        logic  flush;
        string name;
    } vec_t;

    typedef struct {
        logic       pc_write;
        logic       ifid_write;
        logic       ctrl_zero;
        logic       flush;
        logic       busy;
        logic [3:0] cnt;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs, id_rt, ex_wr_addr, mem_wr_addr;
    logic       id_uses_rs, id_uses_rt, id_is_branch, id_is_md, id_reads_hilo;
    logic       ex_mem_read, ex_reg_write, mem_mem_read, branch_taken;
    logic       pc_write, ifid_write, ctrl_set_zero, ifid_flush, md_busy;
    logic [3:0] stall_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0] model_cnt = 4'd0;
    exp_t sb[$];
    vec_t tbl[13];

    pipeline_hazard_ctrl #(.REG_AW(5), .MD_LAT(4), .CNT_W(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .id_rs_i         (id_rs),
        .id_rt_i         (id_rt),
        .id_uses_rs_i    (id_uses_rs),
        .id_uses_rt_i    (id_uses_rt),
        .id_is_branch_i  (id_is_branch),
        .id_is_md_i      (id_is_md),
        .id_reads_hilo_i (id_reads_hilo),
        .ex_mem_read_i   (ex_mem_read),
        .ex_reg_write_i  (ex_reg_write),
        .ex_wr_addr_i    (ex_wr_addr),
        .mem_mem_read_i  (mem_mem_read),
        .mem_wr_addr_i   (mem_wr_addr),
        .branch_taken_i  (branch_taken),
        .pc_write_o      (pc_write),
        .ifid_write_o    (ifid_write),
        .ctrl_set_zero_o (ctrl_set_zero),
        .ifid_flush_o    (ifid_flush),
        .md_busy_o       (md_busy),
        .stall_cnt_o     (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt,
                               input logic br, input logic tk,
                               input logic md, input logic hilo,
                               input logic exr, input logic exw,
                               input logic [4:0] exa,
                               input logic memr, input logic [4:0] mema);
        in_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.br = br; v.tk = tk;
        v.md = md; v.hilo = hilo; v.exr = exr; v.exw = exw; v.exa = exa;
        v.memr = memr; v.mema = mema;
        return v;
    endfunction

    function automatic in_t idle();
        in_t v;
        v = '0;
        return v;
    endfunction

    task automatic drive(input in_t v);
        id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
        id_is_branch = v.br; branch_taken = v.tk; id_is_md = v.md;
        id_reads_hilo = v.hilo; ex_mem_read = v.exr; ex_reg_write = v.exw;
        ex_wr_addr = v.exa; mem_mem_read = v.memr; mem_wr_addr = v.mema;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            chk({e.name, " pc_write"},   {7'd0, pc_write},      {7'd0, e.pc_write});
            chk({e.name, " ifid_write"}, {7'd0, ifid_write},    {7'd0, e.ifid_write});
            chk({e.name, " ctrl_zero"},  {7'd0, ctrl_set_zero}, {7'd0, e.ctrl_zero});
            chk({e.name, " flush"},      {7'd0, ifid_flush},    {7'd0, e.flush});
            chk({e.name, " md_busy"},    {7'd0, md_busy},       {7'd0, e.busy});
            chk({e.name, " stall_cnt"},  {4'd0, stall_cnt},     {4'd0, e.cnt});
        end
    endtask

    // One clock: apply inputs after the edge, queue expectations, check mid-cycle.
    task automatic step(input in_t v, input logic st, input logic fl,
                        input logic bz, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(v);
        e.pc_write = ~st; e.ifid_write = ~st; e.ctrl_zero = st;
        e.flush = fl; e.busy = bz; e.cnt = model_cnt; e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        check_out();
        if (st) model_cnt = (model_cnt == 4'hF) ? 4'hF : model_cnt + 4'd1;
    endtask

    // Hold reset low across the next edge; the following step sees its effect.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(idle());
        model_cnt = 4'd0;
    endtask

    in_t lu8;

    initial begin
        drive(idle());
        //        rs    rt    urs   urt   br    tk    md    hilo  exr   exw   exa    memr  mema
        tbl[0]  = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0), 1'b0, 1'b0, "idle"};
        tbl[1]  = '{mk(5'd8, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0), 1'b1, 1'b0, "lu_rs"};
        tbl[2]  = '{mk(5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0), 1'b1, 1'b0, "lu_rt"};
        tbl[3]  = '{mk(5'd8, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0), 1'b0, 1'b0, "lu_unused_rs"};
        tbl[4]  = '{mk(5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0), 1'b0, 1'b0, "lu_reg0"};
        tbl[5]  = '{mk(5'd8, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0), 1'b0, 1'b0, "alu_fwd"};
        tbl[6]  = '{mk(5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0), 1'b1, 1'b0, "br_ex_alu"};
        tbl[7]  = '{mk(5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9), 1'b1, 1'b0, "br_mem_load"};
        tbl[8]  = '{mk(5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9), 1'b0, 1'b1, "br_mem_alu"};
        tbl[9]  = '{mk(5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 5'd6), 1'b0, 1'b0, "br_nt"};
        tbl[10] = '{mk(5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0), 1'b0, 1'b1, "br_reg0"};
        tbl[11] = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0), 1'b0, 1'b0, "hilo_idle"};
        tbl[12] = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0), 1'b0, 1'b0, "taken_nobr"};
        lu8 = mk(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);

        // Reset state
        do_reset();
        step(idle(), 1'b0, 1'b0, 1'b0, "reset");

        // Combinational table
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].in, tbl[i].stall, tbl[i].flush, 1'b0, tbl[i].name);
        end

        // Load-use: one stall, then the bubble lets the add proceed
        do_reset();
        step(lu8, 1'b1, 1'b0, 1'b0, "lu_seq0");
        step(mk(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8),
             1'b0, 1'b0, 1'b0, "lu_seq1");
        chk("lu_seq stall_cnt", {4'd0, stall_cnt}, 8'd1);

        // Load -> beq taken: two stalls, flush only on the third cycle
        do_reset();
        step(mk(5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0),
             1'b1, 1'b0, 1'b0, "ldbr_c0");
        step(mk(5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9),
             1'b1, 1'b0, 1'b0, "ldbr_c1");
        step(mk(5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
             1'b0, 1'b1, 1'b0, "ldbr_c2");

        // mult then mfhi: stalls cycles 1..4 (cycle 2 also load-use), proceeds cycle 5
        do_reset();
        step(mk(5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
             1'b0, 1'b0, 1'b0, "mul_c0");
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
             1'b1, 1'b0, 1'b1, "mfhi_c1");
        step(mk(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0),
             1'b1, 1'b0, 1'b1, "mfhi_lu_c2");
        for (int c = 3; c <= 4; c++) begin
            step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
                 1'b1, 1'b0, 1'b1, $sformatf("mfhi_c%0d", c));
        end
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
             1'b0, 1'b0, 1'b0, "mfhi_c5");
        chk("mfhi stall_cnt", {4'd0, stall_cnt}, 8'd4);

        // Back-to-back div: second waits for the unit, reloads, then reset mid-busy
        do_reset();
        step(mk(5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
             1'b0, 1'b0, 1'b0, "div1_c0");
        for (int c = 1; c <= 4; c++) begin
            step(mk(5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
                 1'b1, 1'b0, 1'b1, $sformatf("div2_wait_c%0d", c));
        end
        step(mk(5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
             1'b0, 1'b0, 1'b0, "div2_issue_c5");
        step(idle(), 1'b0, 1'b0, 1'b1, "div2_busy_c6");
        step(idle(), 1'b0, 1'b0, 1'b1, "div2_busy_c7");
        chk("div2 stall_cnt", {4'd0, stall_cnt}, 8'd4);
        do_reset();
        step(idle(), 1'b0, 1'b0, 1'b0, "div2_after_reset");

        // md op held by a load-use stall is not issued
        do_reset();
        step(mk(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0),
             1'b1, 1'b0, 1'b0, "md_held");
        step(idle(), 1'b0, 1'b0, 1'b0, "md_not_issued");

        // Saturation: 20 continuous stalls with a 4-bit counter
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step(lu8, 1'b1, 1'b0, 1'b0, $sformatf("sat_c%0d", c));
        end
        step(idle(), 1'b0, 1'b0, 1'b0, "sat_end");
        chk("sat stall_cnt", {4'd0, stall_cnt}, 8'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
